// File: rtl/mem_line_responder.sv
// Line-granular memory responder for the 128-bit L1 cache interface: one
// request at a time, completed after LATENCY cycles with a one-cycle mem_ready.
// Optional per-op completion counters are enabled with MEM_LINE_RESPONDER_STATS_EN.
module mem_line_responder #(
  parameter int ADDR_BITS = 6,
  parameter int LATENCY   = 4
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready
`ifdef MEM_LINE_RESPONDER_STATS_EN
  ,
  output logic [31:0]  stat_reads,
  output logic [31:0]  stat_writes
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);
  localparam int         LINES    = 2 ** ADDR_BITS;

  state_t                 state, state_next;
  logic [7:0]             cnt, cnt_next;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [127:0]           wdata_q;
  logic                   is_write_q;
  logic                   accept;
  logic                   complete;
  logic [127:0]           store [LINES];

  // Upper address bits alias onto the same lines and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[27:ADDR_BITS];

  // NOTE: every output of this block is given a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          accept     = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt != 8'd0) begin
          cnt_next = cnt - 8'd1;
        end else begin
          complete   = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A collision (read and write both high) is captured as a write.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      idx_q      <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      mem_rdata  <= '0;
      mem_ready  <= 1'b0;
    end else begin
      mem_ready <= complete;
      if (accept) begin
        idx_q      <= mem_addr[ADDR_BITS-1:0];
        wdata_q    <= mem_wdata;
        is_write_q <= mem_write;
      end
      if (complete) begin
        mem_rdata <= is_write_q ? wdata_q : store[idx_q];
      end
    end
  end

  // NOTE: the line store has no reset; clearing an array costs a mux per bit
  // and its contents are undefined until written. Reset forces state to IDLE,
  // which suppresses complete, so an abandoned write never commits.
  always_ff @(posedge clk) begin
    if (complete && is_write_q) begin
      store[idx_q] <= wdata_q;
    end
  end

`ifdef MEM_LINE_RESPONDER_STATS_EN
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      stat_reads  <= 32'd0;
      stat_writes <= 32'd0;
    end else if (complete) begin
      if (is_write_q) stat_writes <= stat_writes + 32'd1;
      else            stat_reads  <= stat_reads + 32'd1;
    end
  end
`endif

endmodule
